// File: rtl/issue_pkg.sv
// issue_pkg: shared sizes, grant record and one-hot index helper for the issue scheduler
package issue_pkg;
  localparam int IQ_SIZE_DEF = 16;
  localparam int ISSUE_PORTS_DEF = 2;
  localparam int MUL_LAT_DEF = 4;
  localparam int IQ_IDX_W = $clog2(IQ_SIZE_DEF);
  typedef struct packed {
    logic valid;
    logic [IQ_IDX_W-1:0] idx;
  } grant_t;
  function automatic logic [IQ_IDX_W-1:0] onehot_to_idx(input logic [IQ_SIZE_DEF-1:0] oh);
    logic [IQ_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < IQ_SIZE_DEF; i++)
      if (oh[i]) idx = idx | IQ_IDX_W'(i);
    return idx;
  endfunction
endpackage

// File: rtl/issue_age_matrix.sv
// issue_age_matrix: older[j][i] is set when entry j was allocated before entry i (ISSUE_AGE_SEL_EN builds)
module issue_age_matrix #(
  parameter int IQ_SIZE = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               alloc_valid,
  input  logic [$clog2(IQ_SIZE)-1:0]         alloc_idx,
  output logic [IQ_SIZE-1:0][IQ_SIZE-1:0]    older
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) older <= '0;
    else if (alloc_valid)
      for (int i = 0; i < IQ_SIZE; i++) begin
        older[alloc_idx][i] <= 1'b0;
        older[i][alloc_idx] <= i != int'(alloc_idx);
      end
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: issue select/grant; oldest-first when ISSUE_AGE_SEL_EN is defined, else lowest index first
module issue_scheduler
  import issue_pkg::*;
#(
  parameter int IQ_SIZE = IQ_SIZE_DEF,
  parameter int ISSUE_PORTS = ISSUE_PORTS_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  stall_in,
  input  logic                                  flush,
  input  logic                                  alloc_valid,
  input  logic [$clog2(IQ_SIZE)-1:0]            alloc_idx,
  input  logic [IQ_SIZE-1:0]                    entry_ready,
  input  logic [IQ_SIZE-1:0]                    entry_is_mul,
  input  logic [ISSUE_PORTS-1:0]                port_ready,
  output logic [ISSUE_PORTS-1:0]                grant_valid,
  output logic [ISSUE_PORTS*$clog2(IQ_SIZE)-1:0] grant_idx,
  output logic                                  mul_busy
);
  localparam int IW = $clog2(IQ_SIZE);
  localparam int CW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;
  logic [CW-1:0] busy_cnt;
  logic [IQ_SIZE-1:0] pending, alloc_oh, cand;
  logic go, mul_grant;
  assign alloc_oh = alloc_valid ? IQ_SIZE'(1) << alloc_idx : '0;
  assign cand = entry_ready & ~pending & ~alloc_oh;
  assign go = !stall_in && !flush;
  assign mul_busy = busy_cnt != '0;
`ifdef ISSUE_AGE_SEL_EN
  logic [IQ_SIZE-1:0][IQ_SIZE-1:0] older;
  issue_age_matrix #(.IQ_SIZE(IQ_SIZE)) u_age (
    .clk(clk),
    .rst(rst),
    .alloc_valid(alloc_valid),
    .alloc_idx(alloc_idx),
    .older(older)
  );
`endif
  for (genvar p = 0; p < ISSUE_PORTS; p++) begin : g_port
    logic [IQ_SIZE-1:0] avail, pick, chosen, taken;
    grant_t g;
    if (p == 0) begin : g_alu_mul
      assign avail = cand & ~(mul_busy ? entry_is_mul : '0);
      assign taken = chosen;
    end else begin : g_alu
      assign avail = cand & ~entry_is_mul & ~g_port[p-1].taken;
      assign taken = chosen | g_port[p-1].taken;
    end
`ifdef ISSUE_AGE_SEL_EN
    logic [IQ_SIZE-1:0] unblocked;
    always_comb begin
      unblocked = avail;
      for (int i = 0; i < IQ_SIZE; i++)
        for (int j = 0; j < IQ_SIZE; j++)
          if (avail[j] && older[j][i]) unblocked[i] = 1'b0;
    end
    // lowest-index tiebreak keeps the pick one-hot for never-allocated entries
    assign pick = unblocked & -unblocked;
`else
    assign pick = avail & -avail;
`endif
    assign chosen = port_ready[p] && go ? pick : '0;
    always_ff @(posedge clk or negedge rst)
      if (!rst) g <= '0;
      else begin
        g.valid <= |chosen;
        if (|chosen) g.idx <= onehot_to_idx(chosen);
      end
    assign grant_valid[p] = g.valid;
    assign grant_idx[p*IW +: IW] = g.idx;
  end
  assign mul_grant = |(g_port[0].chosen & entry_is_mul);
  // the counter keeps running through stall and flush: the FU owns an issued mul
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      busy_cnt <= '0;
      pending <= '0;
    end else begin
      pending <= g_port[ISSUE_PORTS-1].taken;
      busy_cnt <= mul_grant ? CW'(MUL_LAT - 1) : mul_busy ? busy_cnt - CW'(1) : busy_cnt;
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: scoreboard bench; expected grants come from a timestamp-age model of the scheduler
module tb_issue_scheduler;
  localparam int IQ = 16, NP = 2, ML = 4, IW = 4;
  logic clk = 0, rst = 0, stall_in = 0, flush = 0, alloc_valid = 0;
  logic [IW-1:0] alloc_idx = '0;
  logic [IQ-1:0] entry_ready = '0, entry_is_mul = '0;
  logic [NP-1:0] port_ready = '0;
  logic [NP-1:0] grant_valid;
  logic [NP*IW-1:0] grant_idx;
  logic mul_busy;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic [NP-1:0] gv;
    logic [NP*IW-1:0] gi;
    logic mb;
  } exp_t;
  exp_t sb [$];
  int stamp [IQ];
  int next_stamp, m_cnt;
  logic [IQ-1:0] m_pend;
  logic [NP*IW-1:0] m_idx;

  issue_scheduler #(.IQ_SIZE(IQ), .ISSUE_PORTS(NP), .MUL_LAT(ML)) dut (
    .clk(clk),
    .rst(rst),
    .stall_in(stall_in),
    .flush(flush),
    .alloc_valid(alloc_valid),
    .alloc_idx(alloc_idx),
    .entry_ready(entry_ready),
    .entry_is_mul(entry_is_mul),
    .port_ready(port_ready),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx),
    .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < IQ; i++) stamp[i] = 0;
    next_stamp = 0;
    m_cnt = 0;
    m_pend = '0;
    m_idx = '0;
    sb.delete();
  endtask

  // smaller allocation stamp = older; equal stamps fall back to lowest index
  task automatic model_eval(output exp_t e);
    logic [IQ-1:0] cand, taken;
    int best, load;
    cand = entry_ready & ~m_pend;
    if (alloc_valid) cand[alloc_idx] = 1'b0;
    taken = '0;
    load = -1;
    e.gv = '0;
    for (int p = 0; p < NP; p++) begin
      best = -1;
      if (port_ready[p] && !stall_in && !flush)
        for (int i = 0; i < IQ; i++) begin
          if (!cand[i] || taken[i]) continue;
          if (entry_is_mul[i] && (p > 0 || m_cnt != 0)) continue;
`ifdef ISSUE_AGE_SEL_EN
          if (best < 0 || stamp[i] < stamp[best]) best = i;
`else
          if (best < 0) best = i;
`endif
        end
      if (best >= 0) begin
        e.gv[p] = 1'b1;
        m_idx[p*IW +: IW] = best[IW-1:0];
        taken[best] = 1'b1;
        if (p == 0 && entry_is_mul[best]) load = ML - 1;
      end
    end
    m_cnt = load >= 0 ? load : (m_cnt > 0 ? m_cnt - 1 : 0);
    m_pend = taken;
    if (alloc_valid) begin
      next_stamp++;
      stamp[alloc_idx] = next_stamp;
    end
    e.gi = m_idx;
    e.mb = m_cnt != 0;
  endtask

  task automatic step();
    exp_t e;
    model_eval(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("grant_valid", grant_valid, e.gv);
    check("grant_idx", grant_idx, e.gi);
    check("mul_busy", mul_busy, e.mb);
  endtask

  task automatic alloc(input int k, input logic mul);
    alloc_valid = 1'b1;
    alloc_idx = k[IW-1:0];
    entry_is_mul[k] = mul;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    entry_ready = '0;
    repeat (n) step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_gv", grant_valid, 0);
    check("rst_gi", grant_idx, 0);
    check("rst_mb", mul_busy, 0);
    rst = 1;
    model_reset();
    port_ready = 2'b11;
    alloc(3, 1);
    alloc(7, 0);
    alloc(8, 0);
    alloc(9, 0);
    entry_ready = 16'h0088;
    step();
    entry_ready = 16'h0300;
    step();
    check("pre_rst_gv", grant_valid, 2'b11);
    check("pre_rst_mb", mul_busy, 1);
    entry_ready = '0;
    #2 rst = 0;
    #1;
    check("async_rst_gv", grant_valid, 0);
    check("async_rst_gi", grant_idx, 0);
    check("async_rst_mb", mul_busy, 0);
    @(posedge clk);
    #1;
    rst = 1;
    model_reset();
    idle(1);
    alloc(5, 0);
    alloc(2, 0);
    alloc(9, 0);
    entry_ready = 16'h0224;
    step();
    check("age_gv", grant_valid, 2'b11);
`ifdef ISSUE_AGE_SEL_EN
    check("age_p0", grant_idx[IW-1:0], 5);
    check("age_p1", grant_idx[2*IW-1:IW], 2);
`else
    check("age_p0", grant_idx[IW-1:0], 2);
    check("age_p1", grant_idx[2*IW-1:IW], 5);
`endif
    step();
    check("pend_gv", grant_valid, 2'b01);
    check("pend_p0", grant_idx[IW-1:0], 9);
    idle(4);
    port_ready = 2'b01;
    alloc(3, 1);
    alloc(4, 1);
    alloc(7, 0);
    entry_ready = 16'h0018;
    step();
    check("mul_p0", grant_idx[IW-1:0], 3);
    check("mul_busy1", mul_busy, 1);
    entry_ready = 16'h0090;
    step();
    check("alu_during_mul", grant_idx[IW-1:0], 7);
    entry_ready = 16'h0010;
    step();
    check("mul_blocked_gv", grant_valid, 0);
    step();
    check("mul_free", mul_busy, 0);
    step();
    check("mul2_gv", grant_valid, 2'b01);
    check("mul2_p0", grant_idx[IW-1:0], 4);
    idle(4);
    port_ready = 2'b11;
    entry_ready = 16'h0018;
    step();
    check("p1_no_mul_gv", grant_valid, 2'b01);
    entry_ready = 16'h0010;
    step();
    check("only_mul_busy_gv", grant_valid, 0);
    idle(4);
    for (int k = 10; k < 14; k++) alloc(k, 0);
    entry_ready = 16'h3C00;
    stall_in = 1;
    step();
    check("stall1_gv", grant_valid, 0);
    step();
    check("stall2_gv", grant_valid, 0);
    stall_in = 0;
    step();
    check("resume_gv", grant_valid, 2'b11);
    check("resume_idx", grant_idx, 8'hBA);
    idle(2);
    entry_is_mul[6] = 0;
    alloc_valid = 1;
    alloc_idx = 6;
    entry_ready = 16'h0040;
    flush = 1;
    step();
    check("flush_gv", grant_valid, 0);
    alloc_valid = 0;
    flush = 0;
    step();
    check("after_flush_p0", grant_idx[IW-1:0], 6);
    idle(2);
    alloc_valid = 1;
    entry_ready = 16'h0040;
    step();
    check("alloc_mask_gv", grant_valid, 0);
    alloc_valid = 0;
    step();
    check("alloc_unmask_gv", grant_valid, 2'b01);
    idle(2);
    for (int c = 0; c < 400; c++) begin
      alloc_valid = 1'($urandom_range(0, 1));
      alloc_idx = IW'($urandom_range(0, IQ - 1));
      entry_is_mul = 16'($urandom) & 16'($urandom);
      entry_ready = 16'($urandom);
      port_ready = NP'($urandom);
      stall_in = $urandom_range(0, 9) == 0;
      flush = $urandom_range(0, 11) == 0;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
